// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: ALU op codes, immediate formats,
// opcode constants and the decoded bundle carried by both pipeline slots.
package decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // M-extension ops occupy 5'b10_xxx so funct3 maps directly onto the low bits.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_AUIPC  = 5'd11,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} stage_state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic            jump_reg;
        result_src_t     result_src;
        alu_op_t         alu_ctrl;
        logic [XLEN-1:0] imm_ext;
        logic            illegal;
    } decoded_t;

    // Shared ALU mapping for OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_t base_alu_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational RV32I decoder: raw instruction -> decoded_t bundle.
// Define DECODE_RV32M_EN to accept the M-extension (MUL/DIV/REM) encodings.
module decoder_core
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output decoded_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic     legal;
    logic     use_rd;
    logic     use_rs1;
    logic     use_rs2;
    logic     use_f3;
    imm_src_t imm_src;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        dec     = '0;
        legal   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        imm_src = IMM_NONE;

        case (opcode)
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                imm_src       = IMM_U;
                use_rd        = 1'b1;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_AUIPC;
                imm_src       = IMM_U;
                use_rd        = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                imm_src        = IMM_J;
                use_rd         = 1'b1;
            end
            OPC_JALR: begin
                legal          = (funct3 == 3'b000);
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jump_reg   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                imm_src        = IMM_I;
                {use_rd, use_rs1, use_f3} = 3'b111;
            end
            OPC_BRANCH: begin
                legal        = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_src      = IMM_B;
                {use_rs1, use_rs2, use_f3} = 3'b111;
            end
            OPC_LOAD: begin
                legal          = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                imm_src        = IMM_I;
                {use_rd, use_rs1, use_f3} = 3'b111;
            end
            OPC_STORE: begin
                legal         = funct3 inside {3'b000, 3'b001, 3'b010};
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_S;
                {use_rs1, use_rs2, use_f3} = 3'b111;
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = base_alu_op(funct3, funct7[5] && (funct3 == 3'b101));
                imm_src       = IMM_I;
                {use_rd, use_rs1, use_f3} = 3'b111;
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                {use_rd, use_rs1, use_rs2, use_f3} = 4'b1111;
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    dec.alu_ctrl = base_alu_op(funct3, funct7 == F7_ALT);
                    legal = (funct7 == F7_BASE) || (funct3 == 3'b000) || (funct3 == 3'b101);
                end else if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
                    dec.alu_ctrl = alu_op_t'({2'b10, funct3});
`else
                    legal = 1'b0;
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_FENCE, OPC_SYSTEM: ;  // legal no-op: no side effects
            default: legal = 1'b0;
        endcase

        dec.rd     = use_rd  ? instr[11:7]  : 5'd0;
        dec.rs1    = use_rs1 ? instr[19:15] : 5'd0;
        dec.rs2    = use_rs2 ? instr[24:20] : 5'd0;
        dec.funct3 = use_f3  ? funct3       : 3'd0;

        case (imm_src)
            IMM_I:   dec.imm_ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   dec.imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   dec.imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   dec.imm_ext = {instr[31:12], 12'b0};
            IMM_J:   dec.imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: dec.imm_ext = '0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-slot skid buffer (main + skid) on a valid/ready handshake.
// Define DECODE_RV32M_EN to enable M-extension decode in decoder_core.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [PC_WIDTH-1:0]   pc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [2:0]            funct3,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  ALUSrc,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  JumpReg,
    output logic [1:0]            ResultSrc,
    output logic [4:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ImmExt,
    output logic                  illegal
);

    if (DATA_WIDTH != XLEN) begin : g_bad_width
        $error("decode_stage: DATA_WIDTH must be 32 for RV32");
    end

    decoded_t     in_dec;
    decoded_t     main_bundle;
    decoded_t     skid_bundle;
    logic [PC_WIDTH-1:0] main_pc;
    logic [PC_WIDTH-1:0] skid_pc;

    stage_state_t state;
    stage_state_t next_state;
    logic         accept;
    logic         pop;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid_in;

    decoder_core u_decoder_core (
        .instr (instr),
        .dec   (in_dec)
    );

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    next_state   = ST_MAIN;
                    load_main_in = 1'b1;
                end
            end
            ST_MAIN: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    next_state   = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    next_state     = ST_MAIN;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
        // A flush discards both held bundles and anything handshaked this cycle.
        if (flush)
            next_state = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_EMPTY;
        else
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        // NOTE: the bundle registers are reset too, so every output reads 0 right after rst.
        if (rst) begin
            main_bundle <= '0;
            main_pc     <= '0;
            skid_bundle <= '0;
            skid_pc     <= '0;
        end else begin
            if (load_main_in) begin
                main_bundle <= in_dec;
                main_pc     <= pc_in;
            end else if (load_main_skid) begin
                main_bundle <= skid_bundle;
                main_pc     <= skid_pc;
            end
            if (load_skid_in) begin
                skid_bundle <= in_dec;
                skid_pc     <= pc_in;
            end
        end
    end

    assign pc_out    = main_pc;
    assign rd        = main_bundle.rd;
    assign rs1       = main_bundle.rs1;
    assign rs2       = main_bundle.rs2;
    assign funct3    = main_bundle.funct3;
    assign RegWrite  = main_bundle.reg_write;
    assign MemWrite  = main_bundle.mem_write;
    assign ALUSrc    = main_bundle.alu_src;
    assign Branch    = main_bundle.branch;
    assign Jump      = main_bundle.jump;
    assign JumpReg   = main_bundle.jump_reg;
    assign ResultSrc = main_bundle.result_src;
    assign ALUctrl   = main_bundle.alu_ctrl;
    assign ImmExt    = main_bundle.imm_ext;
    assign illegal   = main_bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode vectors, skid backpressure, flush and reset.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_decode_stage;

    localparam logic [4:0] EXP_ALU_ADD   = 5'd0;
    localparam logic [4:0] EXP_ALU_PASSB = 5'd10;
    localparam logic [4:0] EXP_ALU_MUL   = 5'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc_out;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        RegWrite, MemWrite, ALUSrc, Branch, Jump, JumpReg;
    logic [1:0]  ResultSrc;
    logic [4:0]  ALUctrl;
    logic [31:0] ImmExt;
    logic        illegal;

    int n_assert = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .ImmExt(ImmExt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // addi xk, x0, k
    function automatic logic [31:0] addi_enc(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_assert++; if ({rd, rs1, rs2, funct3} !== 18'd0) begin n_fail++; $display("FAIL reset_fields: got %0h expected 0", {rd, rs1, rs2, funct3}); end
        n_assert++; if ({RegWrite, MemWrite, ALUSrc, Branch, Jump, JumpReg, ResultSrc, illegal} !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {RegWrite, MemWrite, ALUSrc, Branch, Jump, JumpReg, ResultSrc, illegal}); end
        n_assert++; if (ALUctrl !== EXP_ALU_ADD || ImmExt !== 32'h0 || pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_alu_imm_pc: got %0h/%0h/%0h expected 0/0/0", ALUctrl, ImmExt, pc_out); end
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_addi();
        instr = 32'h00500093; pc_in = 32'h100; in_valid = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b expected 1", out_valid); end
        n_assert++; if (rd !== 5'd1 || rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d expected 1/0", rd, rs1); end
        n_assert++; if (ImmExt !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %0h expected 5", ImmExt); end
        n_assert++; if ({ALUSrc, RegWrite, illegal} !== 3'b110 || ALUctrl !== EXP_ALU_ADD) begin n_fail++; $display("FAIL addi_ctrl: got src/we/ill=%b alu=%0d expected 110/0", {ALUSrc, RegWrite, illegal}, ALUctrl); end
        n_assert++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %0h expected 100", pc_out); end
        in_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_beq();
        instr = 32'hFE208CE3; pc_in = 32'h104; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_assert++; if (Branch !== 1'b1 || RegWrite !== 1'b0 || Jump !== 1'b0) begin n_fail++; $display("FAIL beq_ctrl: got br=%0b we=%0b j=%0b expected 1/0/0", Branch, RegWrite, Jump); end
        n_assert++; if (funct3 !== 3'd0 || rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd0) begin n_fail++; $display("FAIL beq_fields: got f3=%0d rs1=%0d rs2=%0d rd=%0d expected 0/1/2/0", funct3, rs1, rs2, rd); end
        n_assert++; if (ImmExt !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL beq_imm: got %h expected fffffff8", ImmExt); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        instr = 32'h123452B7;  // lui x5, 0x12345
        @(negedge clk);
        n_assert++; if (ImmExt !== 32'h12345000 || ALUctrl !== EXP_ALU_PASSB || rd !== 5'd5 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL lui: got imm=%h alu=%0d rd=%0d we=%0b expected 12345000/10/5/1", ImmExt, ALUctrl, rd, RegWrite); end
        instr = 32'hFE20AE23;  // sw x2, -4(x1)
        @(negedge clk);
        n_assert++; if (ImmExt !== 32'hFFFFFFFC || MemWrite !== 1'b1 || RegWrite !== 1'b0 || funct3 !== 3'd2) begin n_fail++; $display("FAIL sw: got imm=%h mw=%0b we=%0b f3=%0d expected fffffffc/1/0/2", ImmExt, MemWrite, RegWrite, funct3); end
        n_assert++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd0) begin n_fail++; $display("FAIL sw_regs: got %0d/%0d/%0d expected 1/2/0", rs1, rs2, rd); end
        instr = 32'h001000EF;  // jal x1, +2048
        @(negedge clk);
        n_assert++; if (ImmExt !== 32'h00000800 || Jump !== 1'b1 || JumpReg !== 1'b0 || ResultSrc !== 2'b10) begin n_fail++; $display("FAIL jal: got imm=%h j=%0b jr=%0b res=%b expected 800/1/0/10", ImmExt, Jump, JumpReg, ResultSrc); end
        n_assert++; if (rd !== 5'd1 || rs2 !== 5'd0) begin n_fail++; $display("FAIL jal_regs: got rd=%0d rs2=%0d expected 1/0", rd, rs2); end
        instr = 32'h00008067;  // jalr x0, 0(x1)
        @(negedge clk);
        n_assert++; if (JumpReg !== 1'b1 || Jump !== 1'b1 || rs1 !== 5'd1 || ResultSrc !== 2'b10 || ALUSrc !== 1'b1) begin n_fail++; $display("FAIL jalr: got jr=%0b j=%0b rs1=%0d res=%b src=%0b expected 1/1/1/10/1", JumpReg, Jump, rs1, ResultSrc, ALUSrc); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = addi_enc(1); pc_in = 32'h200;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || rd !== 5'd1) begin n_fail++; $display("FAIL bp_first: got rdy=%0b v=%0b rd=%0d expected 1/1/1", in_ready, out_valid, rd); end
        instr = addi_enc(2); pc_in = 32'h204;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b0 || rd !== 5'd1) begin n_fail++; $display("FAIL bp_full: got rdy=%0b rd=%0d expected 0/1", in_ready, rd); end
        instr = addi_enc(3); pc_in = 32'h208;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 5'd1 || pc_out !== 32'h200) begin n_fail++; $display("FAIL bp_hold: got rdy=%0b v=%0b rd=%0d pc=%0h expected 0/1/1/200", in_ready, out_valid, rd, pc_out); end
        out_ready = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b1 || rd !== 5'd2 || pc_out !== 32'h204 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop1: got v=%0b rd=%0d pc=%0h rdy=%0b expected 1/2/204/1", out_valid, rd, pc_out, in_ready); end
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b1 || rd !== 5'd3 || pc_out !== 32'h208) begin n_fail++; $display("FAIL bp_pop2: got v=%0b rd=%0d pc=%0h expected 1/3/208", out_valid, rd, pc_out); end
        instr = addi_enc(4); pc_in = 32'h20C;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b1 || rd !== 5'd4 || ImmExt !== 32'd4) begin n_fail++; $display("FAIL bp_pop3: got v=%0b rd=%0d imm=%0d expected 1/4/4", out_valid, rd, ImmExt); end
        in_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = addi_enc(1); pc_in = 32'h300;
        @(negedge clk);
        instr = addi_enc(2); pc_in = 32'h304;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_setup_full: got %0b expected 0", in_ready); end
        flush = 1'b1; instr = addi_enc(3); pc_in = 32'h308;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full: got v=%0b rdy=%0b expected 0/1", out_valid, in_ready); end
        instr = addi_enc(4); pc_in = 32'h30C;  // handshakes during the flush cycle
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_discard: got %0b expected 0", out_valid); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: got %0b expected 0", out_valid); end
        in_valid = 1'b1; instr = addi_enc(5); pc_in = 32'h310;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b1 || rd !== 5'd5 || pc_out !== 32'h310) begin n_fail++; $display("FAIL flush_recover: got v=%0b rd=%0d pc=%0h expected 1/5/310", out_valid, rd, pc_out); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; instr = 32'h0000007F;
        @(negedge clk);
        n_assert++; if (illegal !== 1'b1 || {RegWrite, MemWrite, Branch, Jump} !== 4'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_7f: got ill=%0b ctrl=%b v=%0b expected 1/0000/1", illegal, {RegWrite, MemWrite, Branch, Jump}, out_valid); end
        instr = 32'h00000000;
        @(negedge clk);
        n_assert++; if (illegal !== 1'b1 || {RegWrite, MemWrite, Branch, Jump} !== 4'b0) begin n_fail++; $display("FAIL ill_zero: got ill=%0b ctrl=%b expected 1/0000", illegal, {RegWrite, MemWrite, Branch, Jump}); end
        instr = 32'h40209033;  // funct7=0100000 with funct3=001 on OP
        @(negedge clk);
        n_assert++; if (illegal !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL ill_funct7: got ill=%0b we=%0b expected 1/0", illegal, RegWrite); end
        instr = 32'h0000000F;  // fence
        @(negedge clk);
        n_assert++; if (illegal !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin n_fail++; $display("FAIL fence_nop: got ill=%0b we=%0b mw=%0b expected 0/0/0", illegal, RegWrite, MemWrite); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        in_valid = 1'b1; instr = 32'h022081B3;  // mul x3, x1, x2
        @(negedge clk);
        in_valid = 1'b0;
`ifdef DECODE_RV32M_EN
        n_assert++; if (ALUctrl !== EXP_ALU_MUL || RegWrite !== 1'b1 || illegal !== 1'b0 || rd !== 5'd3) begin n_fail++; $display("FAIL mul_en: got alu=%0d we=%0b ill=%0b rd=%0d expected 16/1/0/3", ALUctrl, RegWrite, illegal, rd); end
`else
        n_assert++; if (illegal !== 1'b1 || RegWrite !== 1'b0 || ALUctrl === EXP_ALU_MUL) begin n_fail++; $display("FAIL mul_dis: got ill=%0b we=%0b alu=%0d expected 1/0/not 16", illegal, RegWrite, ALUctrl); end
`endif
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = addi_enc(6); pc_in = 32'h400;
        @(negedge clk);
        instr = addi_enc(7); pc_in = 32'h404;
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; instr = addi_enc(8); pc_in = 32'h408;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_hs: got v=%0b rdy=%0b expected 0/1", out_valid, in_ready); end
        n_assert++; if ({rd, rs1, rs2, funct3} !== 18'd0 || ImmExt !== 32'h0 || pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got regs=%0h imm=%0h pc=%0h expected 0/0/0", {rd, rs1, rs2, funct3}, ImmExt, pc_out); end
        n_assert++; if ({RegWrite, ALUSrc, illegal} !== 3'b0 || ALUctrl !== EXP_ALU_ADD) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b alu=%0d expected 000/0", {RegWrite, ALUSrc, illegal}, ALUctrl); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_ghost: got %0b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_mul();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
